banyan_sched: RTL and testbench
===============================

# banyan_sched

Admission scheduler in front of the `banyan` switching network. Takes N independent valid/ready request streams, each carrying data and a destination port. Each cycle it picks a subset that is free of output conflicts and internal link conflicts, and drives the network's `din`/`dst_in`/`in_vld` from registers. Per-output credit counters keep the network, which has no backpressure, from overrunning downstream consumers.

## Interface
- `N`, 4: ports; power of two, 4..32
- `DWIDTH`, 8: payload width
- `CREDITS`, 4: initial and maximum credit per output, 1..255
- `LOGN`, `$clog2(N)`: address width, derived
- `CW`, `$clog2(CREDITS+1)`: credit counter width, derived

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `s_data`  in  [N][DWIDTH]  request payload per input
- `s_dst`  in  [N][LOGN]  requested output port
- `s_valid`  in  [N]  request valid
- `s_ready`  out  [N]  grant; combinational
- `net_din`  out  [N][DWIDTH]  to network `din`; registered
- `net_dst`  out  [N][LOGN]  to network `dst_in`; registered
- `net_vld`  out  [N]  to network `in_vld`; registered
- `credit_ret`  in  [N]  one-cycle pulse, bit j returns one slot for output j
- `credit_cnt`  out  [N][CW]  current credits per output
- `cred_err`  out  1  sticky flag: credit overflow

## Operation
- **Link model.** The link used by a packet from input `src` to `dst` after stage s (0..LOGN-1) is `{dst[s:0], src[LOGN-1:s+1]}`. Stage LOGN-1 yields `dst`. Inputs a and b conflict iff this index matches for any s.
- **Eligibility.** Input i is eligible iff `s_valid[i]` is high and `credit_cnt[s_dst[i]] > 0`.
- **Greedy round-robin scan.** Scan inputs in order `rr_ptr, rr_ptr+1, …` mod N. Grant input i iff it is eligible, has no conflict with any input already granted this cycle, and `credit_cnt[s_dst[i]]` exceeds the grants already made to that output. Because of the link conflict rule, at most one grant goes to each output per cycle.
- **Handshake.** `s_ready[i]` = grant[i]. It may depend on `s_valid`. A transfer occurs when `s_valid & s_ready`. Ungranted requesters must hold their data and destination stable.
- **Network drive.** On each edge: `net_vld <= grant`, `net_din[i] <= s_data[i]`, `net_dst[i] <= s_dst[i]`. Lanes that are not granted keep their previous data; only `net_vld` clears.
- **Round-robin pointer.** If any grant: `rr_ptr <=` (first granted index in scan order + 1) mod N. Otherwise `rr_ptr` holds.
- **Credits, per output j.** `cnt <= cnt - granted_j + credit_ret[j]`.
  - Grant and return in the same cycle leave the count unchanged.
  - A return that would exceed `CREDITS` leaves the count at `CREDITS` and sets `cred_err`.
  - `cred_err` clears only on reset.
- **Reset values.** `net_vld`, `net_din`, `net_dst`, `rr_ptr` and `cred_err` all reset to 0. Every `credit_cnt` resets to `CREDITS`. `s_ready` is forced to 0 while `rst_n` is low.

## Timing
- A request accepted at edge k appears on `net_vld` from k until edge k+1.
- Network traversal adds `NET_LAT = 1 + (LOGN-2)/2` cycles, using integer division. Exported from the package.
- A credit returned at edge k is usable for a grant in the cycle after edge k. There is no same-cycle bypass.
- Reset asserted mid-operation clears all registers immediately and asynchronously. In-flight network data is discarded by the surrounding system.
- Grant logic is combinational, depth O(N²·LOGN). Target N ≤ 16 at full clock rate.

## Structure
- **Package `banyan_pkg`:**
  - function `link_idx(src, dst, s)`
  - function `net_lat(logn)`
  - function `conflict(src_a, dst_a, src_b, dst_b, logn)`
- **Sub-module `banyan_credit_ctr`:** one per output, covering the counter, saturation and error flag. Instantiated N times.
- **Top level:** scan/grant logic, `rr_ptr`, and the output registers.

## Test plan
- **Identity permutation.** N=4, dst {0,1,2,3} all valid, rr=0 → all four granted in one cycle; `net_vld`=4'b1111 the next cycle; `rr_ptr`→1.
- **Internal conflicts.** N=4, dst {0,2,1,3}, rr=0 → cycle 1 grants inputs {0,2} (1 conflicts with 0 at stage 0; 3 conflicts with 2), `rr_ptr`→1. Cycle 2 grants {1,3}.
- **Output contention and fairness.** All four inputs target dst 0 continuously with credits unlimited by returns → grants rotate 0,1,2,3,0…, exactly one per cycle.
- **Credit exhaustion.** `CREDITS`=2, input 0 targets dst 1 continuously, no returns → two grants, then `s_ready[0]`=0. A `credit_ret[1]` pulse at edge k → one grant in the following cycle. Grant and return in the same cycle keep `credit_cnt[1]` constant.
- **Overflow.** `credit_ret[2]` with `credit_cnt[2]`=`CREDITS` → count stays at `CREDITS`, `cred_err`=1 and stays set until reset.
- **Reset mid-operation.** Drop `rst_n` while `net_vld`≠0 → `net_vld`=0 and `s_ready`=0 immediately, counters equal `CREDITS`. After release, the first grant starts the scan at input 0.

Source files
------------

// File: rtl/banyan_pkg.sv
// Shared helpers for the banyan admission scheduler: link addressing,
// pairwise conflict test and network latency.
package banyan_pkg;

    // Link index after stage s: {dst[s:0], src[logn-1:s+1]}
    function automatic int link_idx(int src, int dst, int s, int logn);
        int lo_mask;
        lo_mask = (1 << (s + 1)) - 1;
        return ((dst & lo_mask) << (logn - 1 - s)) | (src >> (s + 1));
    endfunction

    function automatic int net_lat(int logn);
        return 1 + (logn - 2) / 2;
    endfunction

    function automatic logic conflict(int src_a, int dst_a, int src_b, int dst_b, int logn);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < logn; s++)
            if (link_idx(src_a, dst_a, s, logn) == link_idx(src_b, dst_b, s, logn))
                hit = 1'b1;
        return hit;
    endfunction

    localparam int NET_LAT = net_lat(2);

endpackage

// File: rtl/banyan_sched_if.sv
// Request-side valid/ready streams plus network drive and credit signals.
interface banyan_sched_if #(
    parameter int N       = 4,
    parameter int DWIDTH  = 8,
    parameter int CREDITS = 4,
    parameter int LOGN    = $clog2(N),
    parameter int CW      = $clog2(CREDITS + 1)
);
    logic [N-1:0][DWIDTH-1:0] s_data;
    logic [N-1:0][LOGN-1:0]   s_dst;
    logic [N-1:0]             s_valid;
    logic [N-1:0]             s_ready;
    logic [N-1:0][DWIDTH-1:0] net_din;
    logic [N-1:0][LOGN-1:0]   net_dst;
    logic [N-1:0]             net_vld;
    logic [N-1:0]             credit_ret;
    logic [N-1:0][CW-1:0]     credit_cnt;
    logic                     cred_err;

    modport slave (
        input  s_data, s_dst, s_valid, credit_ret,
        output s_ready, net_din, net_dst, net_vld, credit_cnt, cred_err
    );

    modport master (
        output s_data, s_dst, s_valid, credit_ret,
        input  s_ready, net_din, net_dst, net_vld, credit_cnt, cred_err
    );
endinterface

// File: rtl/banyan_credit_ctr.sv
// Per-output credit counter: saturates at CREDITS and latches an overflow flag.
module banyan_credit_ctr #(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          take_i,
    input  logic          ret_i,
    output logic [CW-1:0] cnt_o,
    output logic          err_o
);
    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (take_i && !ret_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else if (ret_i && !take_i) begin
            if (cnt_q == MAX) err_d = 1'b1;
            else              cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= MAX;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;
endmodule

// File: rtl/banyan_sched.sv
// Conflict-free round-robin admission into the banyan network with
// per-output credit flow control and registered network drive.
module banyan_sched
    import banyan_pkg::*;
#(
    parameter int N       = 4,
    parameter int DWIDTH  = 8,
    parameter int CREDITS = 4,
    parameter int LOGN    = $clog2(N),
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    banyan_sched_if.slave  bus
);
    logic [LOGN-1:0]          rr_q, rr_d;
    logic [N-1:0]             grant, take, err;
    logic [N-1:0]             net_vld_q;
    logic [N-1:0][DWIDTH-1:0] net_din_q;
    logic [N-1:0][LOGN-1:0]   net_dst_q;
    logic [N-1:0][CW-1:0]     cnt;

    // Same-output requests always collide on the last stage, so a nonzero
    // credit count is enough to cover every grant made this cycle.
    always_comb begin
        logic [LOGN-1:0] idx;
        logic            blocked;
        logic            found;
        grant   = '0;
        rr_d    = rr_q;
        idx     = '0;
        blocked = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx     = rr_q + LOGN'(k);
            blocked = !bus.s_valid[idx] || (cnt[bus.s_dst[idx]] == '0);
            for (int j = 0; j < N; j++)
                if (grant[j] && conflict(int'(idx), int'(bus.s_dst[idx]),
                                         j, int'(bus.s_dst[j]), LOGN))
                    blocked = 1'b1;
            if (!blocked) begin
                grant[idx] = 1'b1;
                if (!found) begin
                    found = 1'b1;
                    rr_d  = idx + LOGN'(1);
                end
            end
        end
    end

    always_comb begin
        take = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) take[bus.s_dst[i]] = 1'b1;
    end

    for (genvar j = 0; j < N; j++) begin : g_ctr
        banyan_credit_ctr #(.CREDITS(CREDITS), .CW(CW)) u_ctr (
            .clk    (clk),
            .rst_n  (rst_n),
            .take_i (take[j]),
            .ret_i  (bus.credit_ret[j]),
            .cnt_o  (cnt[j]),
            .err_o  (err[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            net_vld_q <= '0;
            net_din_q <= '0;
            net_dst_q <= '0;
        end else begin
            rr_q      <= rr_d;
            net_vld_q <= grant;
            for (int i = 0; i < N; i++)
                if (grant[i]) begin
                    net_din_q[i] <= bus.s_data[i];
                    net_dst_q[i] <= bus.s_dst[i];
                end
        end
    end

    assign bus.s_ready    = grant & {N{rst_n}};
    assign bus.net_vld    = net_vld_q;
    assign bus.net_din    = net_din_q;
    assign bus.net_dst    = net_dst_q;
    assign bus.credit_cnt = cnt;
    assign bus.cred_err   = |err;
endmodule

// File: tb/tb_banyan_sched.sv
// Directed bench for banyan_sched: N=4, DWIDTH=8, CREDITS=2.
module tb_banyan_sched;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    banyan_sched_if #(.N(4), .DWIDTH(8), .CREDITS(2)) bus ();

    banyan_sched #(.N(4), .DWIDTH(8), .CREDITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_valid = '0;
        bus.credit_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.s_valid = 4'hf;
        bus.s_dst = 8'he4;
        bus.s_data = 32'h13121110;
        bus.credit_ret = '0;

        // reset state
        @(negedge clk); #1;
        chk("rst_ready", 32'(bus.s_ready), 32'h0);
        chk("rst_vld", 32'(bus.net_vld), 32'h0);
        chk("rst_din", 32'(bus.net_din), 32'h0);
        chk("rst_dst", 32'(bus.net_dst), 32'h0);
        chk("rst_cnt", 32'(bus.credit_cnt), 32'haa);
        chk("rst_err", 32'(bus.cred_err), 32'h0);

        // identity permutation
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("id_ready", 32'(bus.s_ready), 32'hf);
        post_edge();
        chk("id_vld", 32'(bus.net_vld), 32'hf);
        chk("id_din", 32'(bus.net_din), 32'h13121110);
        chk("id_dst", 32'(bus.net_dst), 32'he4);
        chk("id_cnt", 32'(bus.credit_cnt), 32'h55);
        @(negedge clk);
        bus.s_dst = 8'h00;
        #1 chk("id_rr1_ready", 32'(bus.s_ready), 32'h2);
        post_edge();
        chk("id_rr1_vld", 32'(bus.net_vld), 32'h2);
        chk("id_rr1_dst_hold", 32'(bus.net_dst), 32'he0);
        chk("id_rr1_cnt", 32'(bus.credit_cnt), 32'h54);
        @(negedge clk); #1;
        chk("id_nocred_ready", 32'(bus.s_ready), 32'h0);

        // internal link conflicts
        do_reset();
        bus.s_valid = 4'hf;
        bus.s_dst = 8'hd8;
        #1 chk("cf_c1_ready", 32'(bus.s_ready), 32'h5);
        post_edge();
        chk("cf_c1_vld", 32'(bus.net_vld), 32'h5);
        @(negedge clk);
        bus.s_valid = 4'ha;
        #1 chk("cf_c2_ready", 32'(bus.s_ready), 32'ha);
        post_edge();
        chk("cf_c2_vld", 32'(bus.net_vld), 32'ha);
        chk("cf_cnt", 32'(bus.credit_cnt), 32'h55);

        // output contention and fairness, credit returned every cycle
        do_reset();
        bus.s_valid = 4'hf;
        bus.s_dst = 8'h00;
        bus.credit_ret = 4'h1;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("fair_ready_%0d", c), 32'(bus.s_ready), 32'(4'b1 << (c % 4)));
            post_edge();
            chk($sformatf("fair_cnt_%0d", c), 32'(bus.credit_cnt), 32'haa);
            @(negedge clk);
        end
        bus.credit_ret = '0;
        bus.s_valid = '0;
        #1 chk("fair_err", 32'(bus.cred_err), 32'h0);

        // credit exhaustion and return timing
        do_reset();
        bus.s_valid = 4'h1;
        bus.s_dst = 8'h01;
        #1 chk("ex_g1_ready", 32'(bus.s_ready), 32'h1);
        post_edge();
        chk("ex_g1_cnt", 32'(bus.credit_cnt), 32'ha6);
        @(negedge clk); #1;
        chk("ex_g2_ready", 32'(bus.s_ready), 32'h1);
        post_edge();
        chk("ex_g2_cnt", 32'(bus.credit_cnt), 32'ha2);
        @(negedge clk); #1;
        chk("ex_empty_ready", 32'(bus.s_ready), 32'h0);
        bus.credit_ret = 4'h2;
        post_edge();
        chk("ex_ret_cnt", 32'(bus.credit_cnt), 32'ha6);
        @(negedge clk);
        bus.credit_ret = '0;
        #1 chk("ex_g3_ready", 32'(bus.s_ready), 32'h1);
        post_edge();
        chk("ex_g3_cnt", 32'(bus.credit_cnt), 32'ha2);
        @(negedge clk);
        bus.credit_ret = 4'h2;
        #1 chk("ex_nobypass_ready", 32'(bus.s_ready), 32'h0);
        post_edge();
        chk("ex_ret2_cnt", 32'(bus.credit_cnt), 32'ha6);
        @(negedge clk); #1;
        chk("ex_both_ready", 32'(bus.s_ready), 32'h1);
        post_edge();
        chk("ex_both_cnt", 32'(bus.credit_cnt), 32'ha6);
        chk("ex_err", 32'(bus.cred_err), 32'h0);

        // overflow on output 2
        @(negedge clk);
        bus.s_valid = '0;
        bus.credit_ret = 4'h4;
        post_edge();
        chk("ov_cnt", 32'(bus.credit_cnt), 32'ha6);
        chk("ov_err", 32'(bus.cred_err), 32'h1);
        @(negedge clk);
        bus.credit_ret = '0;
        post_edge();
        post_edge();
        chk("ov_err_sticky", 32'(bus.cred_err), 32'h1);
        chk("ov_cnt_hold", 32'(bus.credit_cnt), 32'ha6);

        // asynchronous reset mid-operation
        @(negedge clk);
        bus.s_valid = 4'hf;
        bus.s_dst = 8'he4;
        post_edge();
        chk("mr_vld_pre", 32'(bus.net_vld), 32'hf);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_vld", 32'(bus.net_vld), 32'h0);
        chk("mr_ready", 32'(bus.s_ready), 32'h0);
        chk("mr_cnt", 32'(bus.credit_cnt), 32'haa);
        chk("mr_err", 32'(bus.cred_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.s_dst = 8'h00;
        #1 chk("mr_rr0_ready", 32'(bus.s_ready), 32'h1);
        post_edge();
        chk("mr_rr0_vld", 32'(bus.net_vld), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
